// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial-subtract FSM states and the default datapath width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int ALU_WIDTH = 10;

endpackage

// File: rtl/fullsub.sv
// One-bit full subtractor cell: dif = A - B - bin, bout set when the bit borrows.
// Purely combinational; no latency, no flow control.
module fullsub (
    output logic dif,
    output logic bout,
    input  logic A,
    input  logic B,
    input  logic bin
);

    assign dif  = A ^ B ^ bin;
    assign bout = (~A & B) | (~A & bin) | (B & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: a - b - bin through one fullsub cell, LSB first.
// Latency WIDTH cycles from accept to done pulse; start is only taken in IDLE, never queued.
module serial_sub_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             bout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    sub_state_t       state;
    sub_state_t       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             cell_dif;
    logic             cell_bout;
    logic             last_bit;

    fullsub u_fullsub (
        .dif  (cell_dif),
        .bout (cell_bout),
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .bin  (brw)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign r_nxt    = {cell_dif, r_sh[WIDTH-1:1]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // busy/done come from their own flops so no output decodes combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            dif  <= '0;
            bout <= 1'b0;
            zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh <= r_nxt;
                    brw  <= cell_bout;
                    cnt  <= cnt + CW'(1);
                    // final bit: publish the assembled word and the borrow out of the MSB
                    if (last_bit) begin
                        dif  <= r_nxt;
                        bout <= cell_bout;
                        zero <= (r_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtract controller for the 10-bit CPU's ALU path. It accepts two WIDTH-bit operands and an initial borrow on a start handshake. It then drives the existing one-bit fullsub cell one bit per cycle, LSB first, carrying the borrow through a flop. It returns the WIDTH-bit difference, the final borrow and a zero flag with a one-cycle done pulse. It trades WIDTH cycles of latency for a single full-subtractor cell instead of a ripple chain.

## Interface
Parameters:
- WIDTH, 10, operand and result width in bits (≥ 2)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  minuend; captured on the accepting edge
- b  in  WIDTH  subtrahend; captured on the accepting edge
- bin  in  1  initial borrow into bit 0; captured on the accepting edge
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result valid
- dif  out  WIDTH  registered difference (a − b − bin) mod 2^WIDTH
- bout  out  1  final borrow out of bit WIDTH−1 (1 ⇒ a < b + bin, unsigned)
- zero  out  1  dif == 0

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - With start=1 at an edge: load a_sh←a, b_sh←b, brw←bin, cnt←0. Go to RUN.
  - With start=0: stay in IDLE.
- RUN: on each edge, one bit is processed.
  - The fullsub cell sees A=a_sh[0], B=b_sh[0], bin=brw.
  - r_sh shifts right, taking the cell's dif into its MSB.
  - brw←cell bout. a_sh and b_sh shift right. cnt←cnt+1.
  - On the edge where cnt==WIDTH−1: load dif←{cell dif, r_sh[WIDTH−1:1]}, bout←cell bout, zero←(that value==0). Go to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing. a, b and bin may change freely after the accepting edge.
- dif, bout and zero change only on the RUN→DONE edge. They hold their value through IDLE until the next result.
- cnt width is clog2(WIDTH). The counter never wraps in normal operation: the terminal compare ends RUN first.
- Arithmetic is unsigned modulo 2^WIDTH. Underflow appears only as bout=1. No saturation.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, dif=0, bout=0, zero=1, cnt=0, brw=0. Shift registers are cleared.
- Reset mid-RUN aborts the operation. No done pulse is issued, and the prior dif/bout are lost (reset values apply).
- Latency: with start accepted at edge E0, done is high for the cycle after edge E_WIDTH (WIDTH cycles after acceptance).
  - busy rises after E0 and falls after E_WIDTH+1.
- Throughput: one result per WIDTH+2 cycles at best.
  - start held high continuously is accepted at E0 and again at E_WIDTH+2.
  - start asserted during the done cycle is not accepted. It must still be high in the following IDLE cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- The shared package alu_pkg holds:
  - the state enum sub_state_t {IDLE, RUN, DONE}
  - the default width constant ALU_WIDTH=10
- One sub-module instance: fullsub (existing one-bit cell, ports dif, bout, A, B, bin), used unchanged as the bit-slice datapath.
- FSM, counter, shift registers and output registers live in serial_sub_ctrl itself.

## Test plan
- Basic subtract: a=5, b=3, bin=0, start pulse. Required response:
  - done exactly 10 cycles after the accepting edge
  - dif=2, bout=0, zero=0
- Underflow: a=3, b=5, bin=0. Required response: dif=0x3FE, bout=1, zero=0.
- Borrow-in and full carry chain: a=0x3FF, b=0x3FF, bin=1. Required response: dif=0x3FF, bout=1.
  - Then a=0x200, b=0x200, bin=0. Required response: dif=0, zero=1, bout=0.
- Start during busy: pulse start with a=7, b=1. Pulse start again 4 cycles later with a=0, b=1.
  - Required: the second start is ignored, a single done pulse, dif=6, busy a single contiguous 11-cycle window.
- Reset mid-operation: start a=9, b=4. Assert rst 5 cycles later.
  - Required: immediate busy=0, dif=0, zero=1, no done pulse.
  - After release, a new start with a=9, b=4 yields dif=5 after 10 cycles.
- Back-to-back: hold start=1 with a=100, b=1. Required response:
  - done pulses at edges 10 and 22 after the first acceptance
  - dif=99 both times, outputs stable between the pulses
